mem_lsu: RTL and testbench

- Load/store unit between the execute stage and the data memory port; the data memory is downstream of it.
- Takes one memory op per handshake, computes the effective address (base + imm), builds a word-aligned request with byte strobes, and waits for grant and read data.
- Aligns and sign/zero-extends load data, then returns a completion to writeback.
- Single outstanding op; flags misalignment and a memory timeout instead of hanging.

---
 rtl/core_pkg.sv | 34 +++
 rtl/mem_lsu_if.sv | 49 ++++
 rtl/lsu_align.sv | 52 +++++
 rtl/mem_lsu.sv | 119 +++++++++++
 tb/tb_mem_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared load/store definitions: RV32 size/sign codes, LSU FSM states and the
// access legality rule applied when an op is accepted.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_e;

    // Unknown size codes and unsigned store codes are rejected like misaligned ops.
    function automatic logic access_illegal(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] ea_lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = ea_lo[0];
            F3_W:        bad = (ea_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad || (is_store && funct3[2]);
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of the LSU's three handshakes: execute request, data memory port and
// writeback completion. The LSU takes the slave view, its environment the master view.
interface mem_lsu_if;
    import core_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_base;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [4:0]      resp_rd;
    logic            resp_load;
    logic            resp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output resp_valid, resp_rdata, resp_rd, resp_load, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_store, req_funct3, req_base, req_imm, req_wdata, req_rd,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  resp_valid, resp_rdata, resp_rd, resp_load, resp_err,
        output resp_ready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/replication and load lane
// select with sign or zero extension. Purely combinational.
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      ea_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_word,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0]   ld_shift;
    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        wstrb = 4'b0000;
        wdata = st_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << ea_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << ea_lo;
                wdata = {2{st_data[15:0]}};
            end
            2'b10: wstrb = 4'b1111;
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign ld_shift = ld_word >> {ea_lo, 3'b000};
    assign ld_byte  = ld_shift[7:0];
    assign ld_half  = ld_shift[15:0];

    always_comb begin
        case (funct3)
            F3_B:    ld_data = XLEN'(ld_byte);
            F3_H:    ld_data = XLEN'(ld_half);
            F3_W:    ld_data = ld_shift;
            F3_BU:   ld_data = XLEN'($unsigned(ld_byte));
            F3_HU:   ld_data = XLEN'($unsigned(ld_half));
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: latches one op, issues a word-aligned
// memory request, waits for grant/read data with a timeout, returns a completion.
module mem_lsu
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e      state, state_nxt;
    logic            op_store;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] op_ea;
    logic [XLEN-1:0] op_wdata;
    logic [4:0]      op_rd;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0] req_ea;
    logic            req_bad;
    logic            abort;
    logic            in_req;
    logic            in_resp;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_ldata;

    assign req_ea  = bus.req_base + bus.req_imm;
    assign req_bad = access_illegal(bus.req_store, bus.req_funct3, req_ea[1:0]);
    assign in_req  = (state == LSU_REQ);
    assign in_resp = (state == LSU_RESP);

    // A grant or read data arriving in the final counted cycle still wins over the abort.
    assign abort = (TIMEOUT != 0) && (cnt == CNT_LAST) &&
                   ((in_req && !bus.mem_gnt) || (state == LSU_WAIT && !bus.mem_rvalid));

    lsu_align u_align (
        .funct3  (op_f3),
        .ea_lo   (op_ea[1:0]),
        .st_data (op_wdata),
        .ld_word (bus.mem_rdata),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ld_data (al_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (bus.req_valid) state_nxt = req_bad ? LSU_RESP : LSU_REQ;
            LSU_REQ: begin
                if (bus.mem_gnt)  state_nxt = op_store ? LSU_RESP : LSU_WAIT;
                else if (abort)   state_nxt = LSU_RESP;
            end
            LSU_WAIT: if (bus.mem_rvalid || abort) state_nxt = LSU_RESP;
            LSU_RESP: if (bus.resp_ready) state_nxt = LSU_IDLE;
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_store <= 1'b0;
            op_f3    <= '0;
            op_ea    <= '0;
            op_wdata <= '0;
            op_rd    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                LSU_IDLE: if (bus.req_valid) begin
                    op_store <= bus.req_store;
                    op_f3    <= bus.req_funct3;
                    op_ea    <= req_ea;
                    op_wdata <= bus.req_wdata;
                    op_rd    <= bus.req_rd;
                    rdata_q  <= '0;
                    err_q    <= req_bad;
                    cnt      <= '0;
                end
                LSU_REQ, LSU_WAIT: begin
                    if (TIMEOUT != 0) cnt <= cnt + 1'b1;
                    if (abort)                                    err_q   <= 1'b1;
                    else if (state == LSU_WAIT && bus.mem_rvalid) rdata_q <= al_ldata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state == LSU_IDLE);
        bus.mem_req    = in_req;
        bus.mem_we     = in_req && op_store;
        bus.mem_addr   = in_req ? {op_ea[XLEN-1:2], 2'b00} : '0;
        bus.mem_wstrb  = (in_req && op_store) ? al_wstrb : 4'b0000;
        bus.mem_wdata  = (in_req && op_store) ? al_wdata : '0;
        bus.resp_valid = in_resp;
        bus.resp_rdata = in_resp ? rdata_q : '0;
        bus.resp_rd    = in_resp ? op_rd : '0;
        bus.resp_load  = in_resp && !op_store;
        bus.resp_err   = in_resp && err_q;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu; expectations come from a byte-level
// memory model and the architectural size/sign/alignment rules.
module tb_mem_lsu;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem_b [256];
    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_err, last_load;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic st, input logic [2:0] f3, input logic [31:0] ea);
        int size;
        size = ref_size(f3);
        if (size == 0 || (size == 4 && f3[2])) return 1'b1;
        if (st && f3[2]) return 1'b1;
        return (ea % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] ea);
        int size;
        longint v;
        logic [31:0] a;
        size = ref_size(f3);
        v = 0;
        for (int i = 0; i < size; i++) begin
            a = ea + 32'(i);
            v = v + (longint'(mem_b[a[7:0]]) << (8 * i));
        end
        if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
            v = v - (longint'(1) << (8 * size));
        return v[31:0];
    endfunction

    // Runs one op end to end; gd = cycles before grant, rvd = cycles before rvalid,
    // rrd = cycles resp_ready is held low.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] rd,
                         input int gd, input int rvd, input int rrd);
        logic [31:0] ea, exp_data, exp_wd, word, a;
        logic [3:0]  exp_strb;
        logic        bad;
        int          size;
        ea = base + imm;
        size = ref_size(f3);
        bad = ref_illegal(st, f3, ea);
        exp_data = '0; exp_wd = '0; exp_strb = '0; word = '0;
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3; bus.req_base = base;
        bus.req_imm = imm; bus.req_wdata = wd; bus.req_rd = rd;
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", bus.req_ready);
        else n_pass++;
        tick();
        bus.req_valid = 1'b0; bus.req_base = $urandom; bus.req_imm = $urandom;
        bus.req_wdata = $urandom; bus.req_rd = 5'($urandom);
        if (!bad) begin
            if (st) begin
                exp_strb = 4'(((1 << size) - 1) << ea[1:0]);
                for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = 8'(wd >> (8 * (l % size)));
            end
            for (int k = 0; k < gd; k++) begin
                n_checks++;
                if (bus.mem_req !== 1'b1) $display("FAIL req_hold: mem_req got %b want 1", bus.mem_req);
                else n_pass++;
                tick();
            end
            n_checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr} !== {1'b1, st, exp_strb, ea[31:2], 2'b00})
                $display("FAIL mem_fields: req/we/strb/addr got %b/%b/%b/%h want 1/%b/%b/%h",
                         bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, st, exp_strb, {ea[31:2], 2'b00});
            else n_pass++;
            if (st) begin
                n_checks++;
                if (bus.mem_wdata !== exp_wd) $display("FAIL mem_wdata: got %h want %h", bus.mem_wdata, exp_wd);
                else n_pass++;
            end
            last_addr = bus.mem_addr; last_wstrb = bus.mem_wstrb; last_wdata = bus.mem_wdata;
            bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
            tick();
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
            if (st) begin
                for (int i = 0; i < size; i++) begin
                    a = ea + 32'(i);
                    mem_b[a[7:0]] = 8'(wd >> (8 * i));
                end
            end else begin
                exp_data = ref_load(f3, ea);
                for (int i = 0; i < 4; i++) word[8*i +: 8] = mem_b[{ea[7:2], 2'(i)}];
                for (int k = 0; k < rvd; k++) begin
                    n_checks++;
                    if ({bus.mem_req, bus.resp_valid} !== 2'b00)
                        $display("FAIL wait_idle: req/resp_valid got %b want 00", {bus.mem_req, bus.resp_valid});
                    else n_pass++;
                    tick();
                end
                bus.mem_rvalid = 1'b1; bus.mem_rdata = word;
                tick();
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            end
        end
        for (int k = 0; k <= rrd; k++) begin
            n_checks++;
            if ({bus.resp_valid, bus.resp_err, bus.resp_load, bus.resp_rd, bus.resp_rdata, bus.req_ready, bus.mem_req}
                !== {1'b1, bad, ~st, rd, exp_data, 1'b0, 1'b0})
                $display("FAIL resp: valid/err/load/rd/rdata/ready/mreq got %b/%b/%b/%0d/%h/%b/%b want 1/%b/%b/%0d/%h/0/0",
                         bus.resp_valid, bus.resp_err, bus.resp_load, bus.resp_rd, bus.resp_rdata,
                         bus.req_ready, bus.mem_req, bad, ~st, rd, exp_data);
            else n_pass++;
            last_rdata = bus.resp_rdata; last_err = bus.resp_err; last_load = bus.resp_load;
            if (k == rrd) bus.resp_ready = 1'b1;
            tick();
        end
        bus.resp_ready = 1'b0;
        n_checks++;
        if ({bus.resp_valid, bus.req_ready} !== 2'b01)
            $display("FAIL post_resp: valid/ready got %b want 01", {bus.resp_valid, bus.req_ready});
        else n_pass++;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.resp_valid,
             bus.resp_rdata, bus.resp_rd, bus.resp_load, bus.resp_err} !== '0)
            $display("FAIL reset_outputs: got nonzero output mem_req=%b resp_valid=%b", bus.mem_req, bus.resp_valid);
        else n_pass++;
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        mem_b[8'h04] = 8'hEF; mem_b[8'h05] = 8'hBE; mem_b[8'h06] = 8'hAD; mem_b[8'h07] = 8'hDE;
        do_op(1'b0, F3_W, 32'h100, 32'h4, 32'h0, 5'd3, 0, 0, 0);
        n_checks++;
        if ({last_addr, last_wstrb, last_rdata, last_load, last_err} !== {32'h104, 4'b0000, 32'hDEADBEEF, 1'b1, 1'b0})
            $display("FAIL lw_plan: addr/strb/rdata got %h/%b/%h want 104/0000/deadbeef", last_addr, last_wstrb, last_rdata);
        else n_pass++;
    endtask

    task automatic test_lb_lbu();
        mem_b[8'h00] = 8'h34; mem_b[8'h01] = 8'h12; mem_b[8'h02] = 8'hFF; mem_b[8'h03] = 8'h80;
        do_op(1'b0, F3_B, 32'h100, 32'h3, 32'h0, 5'd9, 1, 1, 0);
        n_checks++;
        if (last_rdata !== 32'hFFFFFF80) $display("FAIL lb_plan: got %h want ffffff80", last_rdata);
        else n_pass++;
        do_op(1'b0, F3_BU, 32'h100, 32'h3, 32'h0, 5'd10, 0, 2, 1);
        n_checks++;
        if (last_rdata !== 32'h00000080) $display("FAIL lbu_plan: got %h want 00000080", last_rdata);
        else n_pass++;
    endtask

    task automatic test_sh();
        do_op(1'b1, F3_H, 32'h20, 32'h2, 32'h0000ABCD, 5'd4, 2, 0, 0);
        n_checks++;
        if ({last_addr, last_wstrb, last_wdata, last_load} !== {32'h20, 4'b1100, 32'hABCDABCD, 1'b0})
            $display("FAIL sh_plan: addr/strb/wdata/load got %h/%b/%h/%b want 20/1100/abcdabcd/0",
                     last_addr, last_wstrb, last_wdata, last_load);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_op(1'b0, F3_H, 32'h100, 32'h1, 32'h0, 5'd5, 0, 0, 0);
        n_checks++;
        if (last_err !== 1'b1) $display("FAIL lh_misaligned: err got %b want 1", last_err);
        else n_pass++;
        do_op(1'b1, F3_BU, 32'h40, 32'h0, 32'h55, 5'd6, 0, 0, 0);
        do_op(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 5'd7, 0, 0, 0);
        do_op(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 5'd8, 0, 0, 1);
        do_op(1'b1, F3_W, 32'h40, 32'h2, 32'h1, 5'd2, 0, 0, 0);
    endtask

    task automatic test_timeout();
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_W;
        bus.req_base = 32'h200; bus.req_imm = 32'h0; bus.req_rd = 5'd7;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({bus.mem_req, bus.resp_valid} !== 2'b10)
                $display("FAIL to_req_hold: cycle %0d req/valid got %b want 10", i, {bus.mem_req, bus.resp_valid});
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0})
            $display("FAIL to_req_abort: valid/err/rdata/mreq got %b/%b/%h/%b want 1/1/0/0",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_req);
        else n_pass++;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL to_late_rvalid: valid/err/rdata got %b/%b/%h want 1/1/0",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata);
        else n_pass++;
        bus.resp_ready = 1'b1; tick(); bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_base = 32'h204;
        tick();
        bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (bus.resp_valid !== 1'b0) $display("FAIL to_wait_hold: cycle %0d resp_valid got 1 want 0", i);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL to_wait_abort: valid/err/rdata got %b/%b/%h want 1/1/0",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata);
        else n_pass++;
        bus.resp_ready = 1'b1; tick(); bus.resp_ready = 1'b0;
        do_op(1'b0, F3_W, 32'h100, 32'h4, 32'h0, 5'd11, 1, 0, 0);
    endtask

    task automatic test_resp_stall();
        do_op(1'b0, F3_HU, 32'h0, 32'h2, 32'h0, 5'd12, 0, 0, 5);
        do_op(1'b1, F3_B, 32'h10, 32'h1, 32'hA5, 5'd13, 1, 0, 5);
    endtask

    task automatic test_random();
        logic st;
        logic [2:0] f3;
        logic [31:0] base, imm, r;
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 4);
                f3 = st ? 3'(r % 3) : ((r < 3) ? 3'(r) : 3'(r + 1));
            end
            base = $urandom;
            r = $urandom;
            imm = {{20{r[11]}}, r[11:0]};
            if ($urandom_range(0, 1) == 1) begin
                base[1:0] = 2'b00;
                imm[1:0] = 2'b00;
            end
            do_op(st, f3, base, imm, $urandom, 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_in_wait();
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_W;
        bus.req_base = 32'h300; bus.req_imm = 32'h0; bus.req_rd = 5'd15;
        tick();
        bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.req_ready, bus.mem_req, bus.mem_addr, bus.resp_valid, bus.resp_rd, bus.resp_err, bus.resp_load}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0})
            $display("FAIL rst_wait_async: ready/mreq/resp_valid got %b/%b/%b want 1/0/0",
                     bus.req_ready, bus.mem_req, bus.resp_valid);
        else n_pass++;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid = 1'b0;
        n_checks++;
        if ({bus.req_ready, bus.mem_req, bus.resp_valid, bus.resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL rst_wait_edge: ready/mreq/resp_valid/rdata got %b/%b/%b/%h want 1/0/0/0",
                     bus.req_ready, bus.mem_req, bus.resp_valid, bus.resp_rdata);
        else n_pass++;
        rst = 1'b0;
        tick();
        do_op(1'b0, F3_H, 32'h100, 32'h2, 32'h0, 5'd16, 0, 0, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0; bus.req_base = '0;
        bus.req_imm = '0; bus.req_wdata = '0; bus.req_rd = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_timeout();
        test_resp_stall();
        test_random();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
